mtm_alu_deserializer: RTL and testbench



---
 rtl/mtm_alu_deserializer_if.sv | 20 ++
 rtl/mtm_alu_deserializer.sv | 139 +++++++++++++
 tb/tb_mtm_alu_deserializer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mtm_alu_deserializer_if.sv
// Serial input and assembled-record bundle of the mtm_Alu deserializer.
// master: deserializer side, slave: stimulus / consumer side.
interface mtm_alu_deserializer_if;
  logic        sin;
  logic [31:0] a_out;
  logic [31:0] b_out;
  logic [2:0]  op_out;
  logic        out_valid;
  logic [2:0]  err_flags;

  modport master (
    input  sin,
    output a_out, b_out, op_out, out_valid, err_flags
  );

  modport slave (
    output sin,
    input  a_out, b_out, op_out, out_valid, err_flags
  );
endinterface

// File: rtl/mtm_alu_deserializer.sv
// mtm_Alu serial front end: decodes 11-bit packets into B, A, opcode,
// checks count/CRC/opcode and emits one record per frame.
module mtm_alu_deserializer #(
  parameter logic [3:0] CRC_INIT = 4'b0000
) (
  input  logic clk,
  input  logic rst,
  mtm_alu_deserializer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, TYPE, PAYLOAD, STOP, WAIT_HIGH
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  bit_cnt;
  logic        is_ctl;
  logic [7:0]  shreg;
  logic [7:0]  data_q [8];
  logic [3:0]  data_cnt;
  logic        ovf;
  logic        accept, frame_err;

  logic [31:0] a_asm, b_asm;
  logic [31:0] a_q, b_q;
  logic [2:0]  op_q, err_q, err_nxt;
  logic        valid_q;
  logic        crc_ok, op_ok;

  // Serial CRC-4, x^4+x+1, MSB of the message first
  function automatic logic [3:0] crc4(
    input logic [67:0] d,
    input logic [3:0]  init
  );
    logic [3:0] c;
    logic       fb;
    c = init;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ d[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    frame_err = 1'b0;
    unique case (state)
      IDLE:      if (!bus.sin) state_nxt = TYPE;
      TYPE:      state_nxt = PAYLOAD;
      PAYLOAD:   if (bit_cnt == 3'd0) state_nxt = STOP;
      STOP: begin
        if (bus.sin) begin
          accept    = 1'b1;
          state_nxt = IDLE;
        end else begin
          frame_err = 1'b1;
          state_nxt = WAIT_HIGH;
        end
      end
      WAIT_HIGH: if (bus.sin) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    b_asm   = {data_q[0], data_q[1], data_q[2], data_q[3]};
    a_asm   = {data_q[4], data_q[5], data_q[6], data_q[7]};
    crc_ok  = crc4({b_asm, a_asm, 1'b1, shreg[6:4]}, CRC_INIT)
              == shreg[3:0];
    op_ok   = shreg[6:4] inside {3'b000, 3'b001, 3'b100, 3'b101};
    err_nxt = 3'b000;
    if (data_cnt != 4'd8 || ovf) err_nxt = 3'b100;
    else if (!crc_ok)            err_nxt = 3'b010;
    else if (!op_ok)             err_nxt = 3'b001;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= '0;
      is_ctl   <= 1'b0;
      shreg    <= '0;
      data_cnt <= '0;
      ovf      <= 1'b0;
      for (int i = 0; i < 8; i++) data_q[i] <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      err_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (state == TYPE) begin
        is_ctl  <= bus.sin;
        bit_cnt <= 3'd7;
      end
      if (state == PAYLOAD) begin
        shreg   <= {shreg[6:0], bus.sin};
        bit_cnt <= bit_cnt - 3'd1;
      end
      if (frame_err) begin
        data_cnt <= '0;
        ovf      <= 1'b0;
        shreg    <= '0;
        for (int i = 0; i < 8; i++) data_q[i] <= '0;
      end
      if (accept && !is_ctl) begin
        if (data_cnt == 4'd8) begin
          ovf <= 1'b1;
        end else begin
          data_q[data_cnt[2:0]] <= shreg;
          data_cnt <= data_cnt + 4'd1;
        end
      end
      if (accept && is_ctl) begin
        a_q      <= a_asm;
        b_q      <= b_asm;
        op_q     <= shreg[6:4];
        err_q    <= err_nxt;
        valid_q  <= 1'b1;
        data_cnt <= '0;
        ovf      <= 1'b0;
      end
    end
  end

  assign bus.a_out     = a_q;
  assign bus.b_out     = b_q;
  assign bus.op_out    = op_q;
  assign bus.err_flags = err_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Directed bench for mtm_alu_deserializer with a frame-level
// reference model checked every cycle.
module tb_mtm_alu_deserializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mtm_alu_deserializer_if bus ();

  mtm_alu_deserializer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_at = -1;

  logic [7:0]  q [$];
  logic [7:0]  m_slot [8];
  logic [31:0] exp_a = '0, exp_b = '0;
  logic [2:0]  exp_op = '0, exp_err = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h at cyc %0d", nm, act, exp, cyc);
    end
  endtask

  // Remainder of (message * x^4) divided by x^4+x+1
  function automatic logic [3:0] model_crc(input logic [31:0] b,
      input logic [31:0] a, input logic [2:0] op);
    logic [71:0] m;
    m = {b, a, 1'b1, op, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
    return m[3:0];
  endfunction

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 8; i++) m_slot[i] = '0;
    exp_a = '0; exp_b = '0; exp_op = '0; exp_err = '0;
    exp_at = -1;
  endtask

  task automatic model_accept(input bit ctl, input logic [7:0] d);
    int n;
    if (!ctl) begin
      q.push_back(d);
      return;
    end
    n = q.size();
    for (int i = 0; i < n && i < 8; i++) m_slot[i] = q[i];
    exp_b  = {m_slot[0], m_slot[1], m_slot[2], m_slot[3]};
    exp_a  = {m_slot[4], m_slot[5], m_slot[6], m_slot[7]};
    exp_op = d[6:4];
    if (n != 8) exp_err = 3'b100;
    else if (d[3:0] != model_crc(exp_b, exp_a, exp_op)) exp_err = 3'b010;
    else if (!(exp_op inside {3'b000, 3'b001, 3'b100, 3'b101}))
      exp_err = 3'b001;
    else exp_err = 3'b000;
    exp_at = cyc + 1;
    q.delete();
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clk);
    bus.sin = b;
  endtask

  task automatic send_pkt(input bit ctl, input logic [7:0] d,
                          input bit stop = 1'b1);
    drive_bit(1'b0);
    drive_bit(ctl);
    for (int i = 7; i >= 0; i--) drive_bit(d[i]);
    drive_bit(stop);
    if (stop) model_accept(ctl, d);
    else begin
      q.delete();
      for (int i = 0; i < 8; i++) m_slot[i] = '0;
      drive_bit(1'b1);
    end
  endtask

  task automatic send_frame(input logic [31:0] b, input logic [31:0] a,
                            input logic [7:0] ctl);
    for (int i = 3; i >= 0; i--) send_pkt(1'b0, b[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) send_pkt(1'b0, a[i*8 +: 8]);
    send_pkt(1'b1, ctl);
  endtask

  task automatic expect_pulse(input string nm, input logic [2:0] err);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(posedge clk);
      #2;
      if (bus.out_valid === 1'b1) begin
        seen = 1'b1;
        chk({nm, "_err"}, {29'd0, bus.err_flags}, {29'd0, err});
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout act=no_pulse exp=pulse", nm);
    end
  endtask

  // Every-cycle comparison against the model
  always @(posedge clk) begin
    cyc++;
    #1;
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, cyc == exp_at});
    chk("a_out", bus.a_out, exp_a);
    chk("b_out", bus.b_out, exp_b);
    chk("op_out", {29'd0, bus.op_out}, {29'd0, exp_op});
    if (bus.out_valid === 1'b1)
      chk("err_flags", {29'd0, bus.err_flags}, {29'd0, exp_err});
  end

  logic [7:0] ctl_b;

  initial begin
    bus.sin = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("pin_crc_and0", {28'd0, model_crc(0, 0, 3'b000)}, 32'hB);
    chk("pin_crc_add0", {28'd0, model_crc(0, 0, 3'b100)}, 32'h7);
    chk("pin_crc_op2",  {28'd0, model_crc(0, 0, 3'b010)}, 32'hD);
    chk("pin_crc_b2a5", {28'd0, model_crc(32'd2, 32'd5, 3'b100)}, 32'hB);
    @(negedge clk);
    chk("rst_a", bus.a_out, 32'd0);
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);

    send_frame(32'd0, 32'd0, 8'h0B);
    expect_pulse("and0", 3'b000);
    chk("and0_op", {29'd0, bus.op_out}, 32'd0);

    send_frame(32'd0, 32'd0, 8'h47);
    expect_pulse("add0", 3'b000);
    chk("add0_op", {29'd0, bus.op_out}, 32'd4);

    ctl_b = {1'b0, 3'b100, model_crc(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b100)};
    send_frame(32'hFFFFFFFF, 32'hFFFFFFFF, ctl_b);
    expect_pulse("addff", 3'b000);
    chk("addff_a", bus.a_out, 32'hFFFFFFFF);
    chk("addff_b", bus.b_out, 32'hFFFFFFFF);

    send_frame(32'd2, 32'd5, 8'h40);
    expect_pulse("crcerr", 3'b010);

    send_pkt(1'b0, 8'h12);
    send_pkt(1'b0, 8'h34);
    send_pkt(1'b1, 8'h50);
    expect_pulse("cnt2", 3'b100);
    chk("cnt2_b", bus.b_out, 32'h12340002);

    for (int i = 0; i < 9; i++) send_pkt(1'b0, 8'h00);
    send_pkt(1'b1, 8'h0B);
    expect_pulse("cnt9", 3'b100);

    send_frame(32'd0, 32'd0, 8'h0B);
    expect_pulse("recover", 3'b000);

    send_frame(32'd0, 32'd0, 8'h2D);
    expect_pulse("badop", 3'b001);

    send_pkt(1'b0, 8'hAA);
    send_pkt(1'b0, 8'hBB);
    send_pkt(1'b0, 8'hCC, 1'b0);
    repeat (5) drive_bit(1'b1);
    ctl_b = {1'b0, 3'b101, model_crc(32'h01020304, 32'h0A0B0C0D, 3'b101)};
    send_frame(32'h01020304, 32'h0A0B0C0D, ctl_b);
    expect_pulse("sub", 3'b000);
    chk("sub_a", bus.a_out, 32'h0A0B0C0D);
    chk("sub_b", bus.b_out, 32'h01020304);

    for (int i = 0; i < 8; i++) send_pkt(1'b0, 8'h00);
    drive_bit(1'b0);
    drive_bit(1'b1);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    @(negedge clk);
    rst = 1'b1;
    bus.sin = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_a", bus.a_out, 32'd0);
    chk("abort_b", bus.b_out, 32'd0);
    chk("abort_op", {29'd0, bus.op_out}, 32'd0);
    chk("abort_err", {29'd0, bus.err_flags}, 32'd0);

    send_frame(32'd0, 32'd0, 8'h0B);
    expect_pulse("post_rst", 3'b000);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
